exec_pipe: RTL
==============

# exec_pipe

Parametrised, pipelined execute core for the RV32I datapath: the next generation of the single-cycle register-file/operand-select/ALU loop. It accepts already-decoded micro-ops over a valid/ready handshake, reads operands from an internal register file with forwarding, executes, writes back, and streams results out under backpressure. It sits between the instruction decoder and any commit or trace consumer.

## Interface
- XLEN, 32, datapath and register width (≥8)
- NREGS, 32, register count, power of 2; register 0 reads zero and ignores writes
- AW, $clog2(NREGS), register address width (derived, not overridden)
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  micro-op present
- in_ready  out  1  core accepts micro-op this cycle
- in_rs1, in_rs2  in  AW  source register addresses
- in_rd  in  AW  destination address
- in_wen  in  1  write rd with result
- in_imm_en  in  1  operand B = in_imm instead of rs2
- in_imm  in  XLEN  immediate, already sign-extended
- in_op  in  8  ALU operation code
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- out_rd  out  AW  destination of result
- out_wen  out  1  result was written to rd
- out_data  out  XLEN  ALU result
- dbg_addr  in  AW  debug read address
- dbg_data  out  XLEN  register file content at dbg_addr (combinational, no bypass; 0 for address 0)
- retired  out  32  count of completed out handshakes

## Operation
- Two pipeline registers: P1 (accepted op plus latched operand values A, B) and P2 (result).
- advance = !P2_valid || out_ready; in_ready = advance.
- On advance: P1 ← accepted op (P1_valid ← in_valid); P2 ← P1 with ALU result (P2_valid ← P1_valid). No advance: P1, P2 hold all fields.
- Register write: at an advance edge with P1_valid && P1_wen && P1_rd≠0, regfile[P1_rd] ← ALU(P1). Write occurs once, at P1→P2 transfer, independent of later out stall.
- Operand read at accept: A = rs1 value, B = in_imm_en ? in_imm : rs2 value. Source value = 0 if address 0; else P1 ALU result if P1_valid && P1_wen && P1_rd == address (forward); else regfile.
- ALU codes (in_op): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 1/0), 9 SLTU, 10 PASSB. All other codes: result 0, write still honoured.
- Arithmetic modulo 2^XLEN; shift amount = B[$clog2(XLEN)-1:0]; SRA replicates A[XLEN-1].
- out_* driven from P2; out_data/out_rd/out_wen stable while out_valid && !out_ready.
- retired increments by 1 on each out_valid && out_ready edge, wraps at 2^32.

## Timing
- Reset (reset==0 at an edge): P1_valid, P2_valid, all P1/P2 fields, all registers, retired ← 0. Outputs after reset: in_ready=1, out_valid=0, out_rd=0, out_wen=0, out_data=0, retired=0. In-flight ops discarded, not written.
- Latency: op accepted at edge n → out_valid in cycle after edge n+1; register visible to a read accepted at edge n+1 via forward, at edge n+2 and later via regfile.
- Throughput: one op per cycle while out_ready=1; back-to-back dependent ops need no bubble.
- out_ready low with P2_valid: in_ready drops same cycle (combinational), pipeline frozen, no regfile write.
- P2 empty: advance regardless of out_ready (bubbles squeeze out).
- Simultaneous rs1==rs2==P1_rd: both operands forwarded.
- in_valid while in_ready=0: ignored; producer holds.

## Test plan
- Reset then ADD rd=1, rs1=0, imm_en, imm=5 → out_data=5, out_rd=1 two edges after accept; dbg_addr=1 reads 5; retired=1.
- Back-to-back: x1=5, then ADD x2=x1+x1 (rs1=rs2=1) next cycle → out_data=10 (forwarding), then SUB x3=x2-imm 12 → 0xFFFFFFFE.
- Stall: hold out_ready=0 with P2 full → in_ready=0, out_data stable for 5 cycles, retired unchanged; release → all queued results in order.
- ALU sweep: SRA 0x80000000 by 4 → 0xF8000000; SLT −1<1 → 1; SLTU 0xFFFFFFFF<1 → 0; opcode 200 → 0.
- Write to register 0 with wen=1, imm=7 → out_data=7, dbg_addr=0 reads 0, later rs1=0 read gives 0.
- Assert reset mid-stream with two ops in flight → out_valid=0 next cycle, x registers all 0, retired=0, target registers never written.

Source files
------------

// File: rtl/exec_pipe.sv
// Two-stage RV32I execute core: register file with forwarding, ALU and writeback,
// streaming results out over a valid/ready handshake.
module exec_pipe #(
   parameter  int XLEN  = 32,
   parameter  int NREGS = 32,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [AW-1:0]   in_rs1,
   input  logic [AW-1:0]   in_rs2,
   input  logic [AW-1:0]   in_rd,
   input  logic            in_wen,
   input  logic            in_imm_en,
   input  logic [XLEN-1:0] in_imm,
   input  logic [7:0]      in_op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [AW-1:0]   out_rd,
   output logic            out_wen,
   output logic [XLEN-1:0] out_data,
   input  logic [AW-1:0]   dbg_addr,
   output logic [XLEN-1:0] dbg_data,
   output logic [31:0]     retired
);

   localparam int SHW = $clog2(XLEN);

   logic [XLEN-1:0] regs [NREGS];

   logic            p1_valid;
   logic [AW-1:0]   p1_rd;
   logic            p1_wen;
   logic [7:0]      p1_op;
   logic [XLEN-1:0] p1_a;
   logic [XLEN-1:0] p1_b;

   logic            p2_valid;
   logic [AW-1:0]   p2_rd;
   logic            p2_wen;
   logic [XLEN-1:0] p2_data;

   logic            advance;
   logic [XLEN-1:0] alu_res;
   logic [SHW-1:0]  shamt;
   logic            fwd1;
   logic            fwd2;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;

   // Handshake: a transfer happens on an edge where valid && ready; a producer
   // holding valid must keep its payload stable until ready is seen high.
   // The whole pipe moves together whenever the output slot can drain or is empty.
   assign advance  = !p2_valid || out_ready;
   assign in_ready = advance;

   assign out_valid = p2_valid;
   assign out_rd    = p2_rd;
   assign out_wen   = p2_wen;
   assign out_data  = p2_data;

   assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

   // Forward from P1 because its result lands in the regfile on the same edge the
   // new op latches its operands.
   assign fwd1    = p1_valid && p1_wen && (p1_rd == in_rs1);
   assign fwd2    = p1_valid && p1_wen && (p1_rd == in_rs2);
   assign rs1_val = (in_rs1 == '0) ? '0 : (fwd1 ? alu_res : regs[in_rs1]);
   assign rs2_val = (in_rs2 == '0) ? '0 : (fwd2 ? alu_res : regs[in_rs2]);

   assign shamt = p1_b[SHW-1:0];

   always_comb begin
      alu_res = '0;
      case (p1_op)
         8'd0:    alu_res = p1_a + p1_b;
         8'd1:    alu_res = p1_a - p1_b;
         8'd2:    alu_res = p1_a & p1_b;
         8'd3:    alu_res = p1_a | p1_b;
         8'd4:    alu_res = p1_a ^ p1_b;
         8'd5:    alu_res = p1_a << shamt;
         8'd6:    alu_res = p1_a >> shamt;
         8'd7:    alu_res = $signed(p1_a) >>> shamt;
         8'd8:    alu_res = {{(XLEN-1){1'b0}}, $signed(p1_a) < $signed(p1_b)};
         8'd9:    alu_res = {{(XLEN-1){1'b0}}, p1_a < p1_b};
         8'd10:   alu_res = p1_b;
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         p1_valid <= 1'b0;
         p1_rd    <= '0;
         p1_wen   <= 1'b0;
         p1_op    <= '0;
         p1_a     <= '0;
         p1_b     <= '0;
         p2_valid <= 1'b0;
         p2_rd    <= '0;
         p2_wen   <= 1'b0;
         p2_data  <= '0;
         retired  <= '0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         if (advance) begin
            p1_valid <= in_valid;
            p1_rd    <= in_rd;
            p1_wen   <= in_wen;
            p1_op    <= in_op;
            p1_a     <= rs1_val;
            p1_b     <= in_imm_en ? in_imm : rs2_val;
            p2_valid <= p1_valid;
            p2_rd    <= p1_rd;
            p2_wen   <= p1_wen;
            p2_data  <= alu_res;
            if (p1_valid && p1_wen && (p1_rd != '0)) regs[p1_rd] <= alu_res;
         end
         if (p2_valid && out_ready) retired <= retired + 32'd1;
      end
   end

endmodule
